// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory arbiter: FSM encoding, error data, grant indices.
package mem_arb_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; last_grant advances only when the pick is taken.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    logic last_q, last_d;

    always_comb begin
        grant_valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~last_q;
        end else if (req_i[1]) begin
            grant_o = M1;
        end else begin
            grant_o = M0;
        end
        last_d = (take_i && grant_valid_o) ? grant_o : last_q;
    end

    // Reset to M1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two native-bus masters onto one single-port slave: IDLE -> ISSUE -> WAIT -> RESP,
// with a WAIT-state timeout that answers ERR_DATA instead of hanging the master.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              s_select,
    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_wstrb,
    output logic [31:0]       s_data_i,
    input  logic              s_ready,
    input  logic [31:0]       s_data_o,
    output logic              timeout_err
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              to_q, to_d;
    logic              pick, pick_valid, take;

    rr_arb2 u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_i         ({m1_valid, m0_valid}),
        .take_i        (take),
        .grant_o       (pick),
        .grant_valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    take    = 1'b1;
                    gnt_d   = pick;
                    addr_d  = (pick == M1) ? m1_addr  : m0_addr;
                    wdata_d = (pick == M1) ? m1_wdata : m0_wdata;
                    wstrb_d = (pick == M1) ? m1_wstrb : m0_wstrb;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (s_ready) begin
                    rdata_d = s_data_o;
                    state_d = StResp;
                end else if (cnt_q == TimeoutCnt) begin
                    rdata_d = ERR_DATA;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= M0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Read data is shared; only the per-master ready qualifies it.
    assign s_select    = (state_q == StIssue);
    assign s_addr      = addr_q;
    assign s_wstrb     = wstrb_q;
    assign s_data_i    = wdata_q;
    assign m0_ready    = (state_q == StResp) && (gnt_q == M0);
    assign m1_ready    = (state_q == StResp) && (gnt_q == M1);
    assign m0_rdata    = rdata_q;
    assign m1_rdata    = rdata_q;
    assign timeout_err = to_q;

endmodule
